// File: rtl/hs_arbiter.sv
// hs_arbiter: two-port round-robin arbiter in front of the single handshake
// (hs) port of the AXI master.
//
// One transaction at a time is serialised downstream. The granted port's
// address, write data and op are latched on grant and held through DONE.
// Strobes and done pulses are decoded from registered state only, and
// DONE+IDLE give at least two low strobe cycles between transactions, so the
// master always sees a fresh rising edge.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-low reset
//   sN_read_i/sN_write_i    level requests (read wins if both high)
//   sN_addr_i/sN_data_i     request address / write data, held until done
//   sN_done_o               one-cycle completion pulse
//   sN_rdata_o              registered read data, held until next read
//   m_read_o/m_write_o      downstream strobes
//   m_addr_o/m_data_o       latched downstream address / write data
//   m_ready_i, m_data_i     downstream idle flag / read data
//   busy_o                  high whenever the FSM is not in IDLE

// Per-port slice: request decode and read-data register.
module hs_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] m_data_i,
  output logic              req,
  output logic              is_read,
  output logic [DATA_W-1:0] rdata
);
  assign req     = read_i | write_i;
  // A read on the same port masks a simultaneous write.
  assign is_read = read_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i)      rdata <= '0;
    else if (load_i) rdata <= m_data_i;
  end
endmodule

module hs_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s0_read_i,
  input  logic              s0_write_i,
  input  logic [ADDR_W-1:0] s0_addr_i,
  input  logic [DATA_W-1:0] s0_data_i,
  output logic              s0_done_o,
  output logic [DATA_W-1:0] s0_rdata_o,
  input  logic              s1_read_i,
  input  logic              s1_write_i,
  input  logic [ADDR_W-1:0] s1_addr_i,
  input  logic [DATA_W-1:0] s1_data_i,
  output logic              s1_done_o,
  output logic [DATA_W-1:0] s1_rdata_o,
  output logic              m_read_o,
  output logic              m_write_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  input  logic [DATA_W-1:0] m_data_i,
  output logic              busy_o
);
  localparam int NUM_PORTS = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state_q;
  logic                    gnt_q;       // port owning the current transaction
  logic                    last_q;      // round-robin pointer: last granted port
  logic                    op_rd_q;
  logic                    seen_low_q;  // master has dropped ready this transaction
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       data_q;

  logic [NUM_PORTS-1:0]             read, write, req, rd, load, done;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;
  logic                             pick;

  assign read  = {s1_read_i,  s0_read_i};
  assign write = {s1_write_i, s0_write_i};
  assign addr  = {s1_addr_i,  s0_addr_i};
  assign wdata = {s1_data_i,  s0_data_i};

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign done[p] = (state_q == S_DONE) && (gnt_q == 1'(p));
      assign load[p] = done[p] && op_rd_q;

      hs_arbiter_port #(.DATA_W(DATA_W)) u_port (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .read_i   (read[p]),
        .write_i  (write[p]),
        .load_i   (load[p]),
        .m_data_i (m_data_i),
        .req      (req[p]),
        .is_read  (rd[p]),
        .rdata    (rdata[p])
      );
    end
  endgenerate

  // Contention goes to the port not granted last; otherwise the lone requester.
  always_comb begin
    pick = req[1];
    if (&req) pick = ~last_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      op_rd_q    <= 1'b0;
      seen_low_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Master still busy (ready low) blocks any new issue.
          if (m_ready_i && (|req)) begin
            gnt_q   <= pick;
            last_q  <= pick;
            op_rd_q <= rd[pick];
            addr_q  <= addr[pick];
            data_q  <= wdata[pick];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          seen_low_q <= ~m_ready_i;
          state_q    <= S_BUSY;
        end
        S_BUSY: begin
          // Ready high before any low is stale (master has not yet taken the
          // strobe edge), so completion requires low-then-high.
          if (!m_ready_i)      seen_low_q <= 1'b1;
          else if (seen_low_q) state_q    <= S_DONE;
        end
        default: state_q <= S_IDLE;  // S_DONE
      endcase
    end
  end

  assign m_read_o   = ((state_q == S_ISSUE) || (state_q == S_BUSY)) &&  op_rd_q;
  assign m_write_o  = ((state_q == S_ISSUE) || (state_q == S_BUSY)) && !op_rd_q;
  assign m_addr_o   = addr_q;
  assign m_data_o   = data_q;
  assign busy_o     = (state_q != S_IDLE);
  assign s0_done_o  = done[0];
  assign s1_done_o  = done[1];
  assign s0_rdata_o = rdata[0];
  assign s1_rdata_o = rdata[1];
endmodule

// File: tb/tb_hs_arbiter.sv
// Directed bench for hs_arbiter with a small behavioural hs master.
module tb_hs_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_read, s0_write, s1_read, s1_write;
  logic [31:0] s0_addr, s0_data, s1_addr, s1_data;
  logic        s0_done, s1_done;
  logic [31:0] s0_rdata, s1_rdata;
  logic        m_read, m_write, m_ready, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // master model controls
  int   busy_cycles = 1;
  int   early_hold  = 0;
  bit   force_busy  = 1'b0;
  int   mphase = 0;
  int   mcnt   = 0;
  logic prev_strobe = 1'b0;

  // monitor
  int done0_cnt = 0;
  int done1_cnt = 0;
  int order[$];
  int min_gap = 99;
  int low_run = 0;
  bit had_strobe = 1'b0;

  always #5 clk = ~clk;

  hs_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .s0_read_i(s0_read), .s0_write_i(s0_write), .s0_addr_i(s0_addr), .s0_data_i(s0_data),
    .s0_done_o(s0_done), .s0_rdata_o(s0_rdata),
    .s1_read_i(s1_read), .s1_write_i(s1_write), .s1_addr_i(s1_addr), .s1_data_i(s1_data),
    .s1_done_o(s1_done), .s1_rdata_o(s1_rdata),
    .m_read_o(m_read), .m_write_o(m_write), .m_addr_o(m_addr), .m_data_o(m_wdata),
    .m_ready_i(m_ready), .m_data_i(m_rdata), .busy_o(busy)
  );

  // hs master: on a strobe rising edge optionally keeps ready high for
  // early_hold cycles, then drops it for busy_cycles, then raises it.
  always @(negedge clk) begin
    logic strobe;
    strobe = m_read | m_write;
    if (!rst_n) begin
      m_ready = 1'b1; mphase = 0; mcnt = 0;
    end else begin
      case (mphase)
        0: if (strobe && !prev_strobe) begin
             if (early_hold > 0) begin mphase = 1; mcnt = early_hold - 1; m_ready = 1'b1; end
             else begin mphase = 2; mcnt = busy_cycles - 1; m_ready = 1'b0; end
           end else m_ready = !force_busy;
        1: if (mcnt > 0) mcnt--;
           else begin mphase = 2; mcnt = busy_cycles - 1; m_ready = 1'b0; end
        2: if (mcnt > 0) mcnt--;
           else begin mphase = 3; m_ready = 1'b1; end
        default: if (!strobe) mphase = 0;
      endcase
    end
    prev_strobe = strobe;
  end

  always @(negedge clk) begin
    if (s0_done) begin done0_cnt++; order.push_back(0); end
    if (s1_done) begin done1_cnt++; order.push_back(1); end
    if (m_read | m_write) begin
      if (had_strobe && low_run > 0 && low_run < min_gap) min_gap = low_run;
      had_strobe = 1'b1;
      low_run = 0;
    end else low_run++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_done(input int port, output int lat);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if ((port == 0) ? s0_done : s1_done) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_addr = 0; s0_data = 0; s1_addr = 0; s1_data = 0; m_rdata = 0;
    tick(3);
    n_cmp++; if ({m_read, m_write, busy, s0_done, s1_done} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {m_read, m_write, busy, s0_done, s1_done}); end
    n_cmp++; if (m_addr !== 32'h0 || m_wdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_mbus: got addr %h data %h want 0 0", m_addr, m_wdata); end
    n_cmp++; if (s0_rdata !== 32'h0 || s1_rdata !== 32'h0) begin n_bad++;
      $display("FAIL reset_rdata: got %h %h want 0 0", s0_rdata, s1_rdata); end
    rst_n = 1'b1;
    tick(2);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_read;
    int lat;
    busy_cycles = 5; m_rdata = 32'hDEADBEEF;
    s0_read = 1; s0_addr = 32'h1000;
    tick();
    n_cmp++; if (m_read !== 1'b1 || m_write !== 1'b0 || m_addr !== 32'h1000 || busy !== 1'b1) begin n_bad++;
      $display("FAIL rd_issue: got rd %b wr %b addr %h busy %b want 1 0 1000 1", m_read, m_write, m_addr, busy); end
    wait_done(0, lat);
    s0_read = 0;
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL rd_latency: got %0d want 6", lat); end
    n_cmp++; if (m_read !== 1'b0 || s1_done !== 1'b0) begin n_bad++;
      $display("FAIL rd_done_cycle: got strobe %b s1_done %b want 0 0", m_read, s1_done); end
    tick();
    n_cmp++; if (s0_done !== 1'b0) begin n_bad++; $display("FAIL rd_pulse_width: got %b want 0", s0_done); end
    tick();
    n_cmp++; if (s0_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", s0_rdata); end
    n_cmp++; if (done0_cnt !== 1 || done1_cnt !== 0) begin n_bad++;
      $display("FAIL rd_done_count: got %0d %0d want 1 0", done0_cnt, done1_cnt); end
  endtask

  task automatic test_single_write;
    int lat, unstable;
    busy_cycles = 2; m_rdata = 32'hAAAA5555;
    s1_write = 1; s1_addr = 32'h2004; s1_data = 32'h12345678;
    tick();
    n_cmp++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_addr !== 32'h2004 || m_wdata !== 32'h12345678) begin n_bad++;
      $display("FAIL wr_issue: got wr %b rd %b addr %h data %h", m_write, m_read, m_addr, m_wdata); end
    lat = 0; unstable = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (m_wdata !== 32'h12345678 || m_addr !== 32'h2004) unstable++;
      if (s1_done) break;
    end
    s1_write = 0;
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", lat); end
    n_cmp++; if (unstable !== 0) begin n_bad++; $display("FAIL wr_hold: got %0d unstable cycles want 0", unstable); end
    tick(2);
    n_cmp++; if (s1_rdata !== 32'h0 || s0_rdata !== 32'hDEADBEEF) begin n_bad++;
      $display("FAIL wr_rdata_kept: got %h %h want 0 deadbeef", s1_rdata, s0_rdata); end
    n_cmp++; if (done1_cnt !== 1 || done0_cnt !== 1) begin n_bad++;
      $display("FAIL wr_done_count: got %0d %0d want 1 1", done0_cnt, done1_cnt); end
  endtask

  task automatic test_contention;
    int n = 0;
    busy_cycles = 1;
    order.delete(); min_gap = 99; had_strobe = 0;
    s0_read = 1; s0_addr = 32'h100;
    s1_write = 1; s1_addr = 32'h200; s1_data = 32'h55;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (s0_done || s1_done) n++;
    end
    s0_read = 0; s1_write = 0;
    tick(3);
    n_cmp++; if (order.size() !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      n_cmp++; if (order[i] !== (i % 2)) begin n_bad++;
        $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
    n_cmp++; if (min_gap !== 2) begin n_bad++; $display("FAIL strobe_gap: got %0d want 2", min_gap); end
  endtask

  task automatic test_read_write_same_port;
    int lat;
    busy_cycles = 1; m_rdata = 32'h0BADF00D;
    s0_read = 1; s0_write = 1; s0_addr = 32'h3000; s0_data = 32'h77;
    tick();
    n_cmp++; if (m_read !== 1'b1 || m_write !== 1'b0) begin n_bad++;
      $display("FAIL rw_same_port: got rd %b wr %b want 1 0", m_read, m_write); end
    wait_done(0, lat);
    s0_read = 0; s0_write = 0;
    tick(2);
    n_cmp++; if (s0_rdata !== 32'h0BADF00D) begin n_bad++; $display("FAIL rw_rdata: got %h want 0badf00d", s0_rdata); end
  endtask

  task automatic test_early_ready;
    int lat;
    busy_cycles = 2; early_hold = 3; m_rdata = 32'hCAFEF00D;
    s1_read = 1; s1_addr = 32'h4000;
    tick();
    n_cmp++; if (m_read !== 1'b1 || m_addr !== 32'h4000) begin n_bad++;
      $display("FAIL early_issue: got rd %b addr %h want 1 4000", m_read, m_addr); end
    wait_done(1, lat);
    s1_read = 0; early_hold = 0;
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL early_ready_latency: got %0d want 6", lat); end
    tick(2);
    n_cmp++; if (s1_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL early_rdata: got %h want cafef00d", s1_rdata); end
  endtask

  task automatic test_blocked_issue;
    int lat;
    bit seen = 0;
    force_busy = 1; busy_cycles = 1; m_rdata = 32'h600D600D;
    tick(2);
    s0_read = 1; s0_addr = 32'h6000;
    tick(3);
    n_cmp++; if (busy !== 1'b0 || m_read !== 1'b0) begin n_bad++;
      $display("FAIL blocked_issue: got busy %b rd %b want 0 0", busy, m_read); end
    force_busy = 0;
    for (int i = 0; i < 5 && !seen; i++) begin tick(); seen = m_read; end
    n_cmp++; if (seen !== 1'b1 || m_addr !== 32'h6000) begin n_bad++;
      $display("FAIL unblocked_issue: got rd %b addr %h want 1 6000", seen, m_addr); end
    wait_done(0, lat);
    s0_read = 0;
    n_cmp++; if (lat > 3) begin n_bad++; $display("FAIL unblocked_done: got latency %0d want <=3", lat); end
    tick(2);
  endtask

  task automatic test_mid_reset;
    int lat, d0, d1;
    busy_cycles = 10; m_rdata = 32'h11112222;
    s0_read = 1; s0_addr = 32'h5000;
    tick(3);
    n_cmp++; if (m_read !== 1'b1 || busy !== 1'b1) begin n_bad++;
      $display("FAIL mid_pre: got rd %b busy %b want 1 1", m_read, busy); end
    d0 = done0_cnt; d1 = done1_cnt;
    rst_n = 0; s0_read = 0;
    tick();
    n_cmp++; if ({m_read, m_write, busy, s0_done, s1_done} !== 5'b0) begin n_bad++;
      $display("FAIL mid_reset_ctrl: got %b want 00000", {m_read, m_write, busy, s0_done, s1_done}); end
    n_cmp++; if (m_addr !== 32'h0 || m_wdata !== 32'h0 || s0_rdata !== 32'h0 || s1_rdata !== 32'h0) begin n_bad++;
      $display("FAIL mid_reset_data: got %h %h %h %h want all 0", m_addr, m_wdata, s0_rdata, s1_rdata); end
    tick();
    rst_n = 1;
    tick(2);
    n_cmp++; if (done0_cnt !== d0 || done1_cnt !== d1) begin n_bad++;
      $display("FAIL mid_reset_no_done: got %0d %0d want %0d %0d", done0_cnt, done1_cnt, d0, d1); end
    // pointer back at reset value: contention goes to port 0
    busy_cycles = 1;
    s0_read = 1; s0_addr = 32'h5100;
    s1_write = 1; s1_addr = 32'h5200; s1_data = 32'h9;
    tick();
    n_cmp++; if (m_read !== 1'b1 || m_addr !== 32'h5100) begin n_bad++;
      $display("FAIL post_reset_grant: got rd %b addr %h want 1 5100", m_read, m_addr); end
    wait_done(0, lat);
    s0_read = 0;
    wait_done(1, lat);
    s1_write = 0;
    n_cmp++; if (lat > 6) begin n_bad++; $display("FAIL pending_served: got latency %0d want <=6", lat); end
    // lone s1 after reset is granted immediately
    rst_n = 0;
    tick(2);
    rst_n = 1;
    tick();
    s1_write = 1; s1_addr = 32'h5300;
    tick();
    n_cmp++; if (m_write !== 1'b1 || m_addr !== 32'h5300) begin n_bad++;
      $display("FAIL lone_s1_grant: got wr %b addr %h want 1 5300", m_write, m_addr); end
    wait_done(1, lat);
    s1_write = 0;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_read_write_same_port();
    test_early_ready();
    test_blocked_issue();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
